// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the five-stage CPU pipeline registers.
package cpu_pipe_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    // Forwarding-data source indices into the fwd_src bus
    localparam int unsigned FWD_SRC_ALU = 0;
    localparam int unsigned FWD_SRC_PC8 = 1;
    localparam int unsigned FWD_SRC_HI  = 2;
    localparam int unsigned FWD_SRC_LO  = 3;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous active-low reset.
module pipe_sat_counter #(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    output logic [CNTW-1:0] cnt
);

    // Clear beats increment; increment stops at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNTW'(1);
        end
    end

endmodule

// File: rtl/mem_stage_pipe_reg.sv
// EX->MEM pipeline register with stall/flush, forwarding-source select and
// saturating stall/bubble performance counters.
module mem_stage_pipe_reg #(
    parameter  int unsigned DW   = cpu_pipe_pkg::DW,
    parameter  int unsigned AW   = cpu_pipe_pkg::AW,
    parameter  int unsigned NSRC = 4,
    parameter  int unsigned CNTW = 16,
    localparam int unsigned SELW = $clog2(NSRC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [DW-1:0]        ir_i,
    input  logic [DW-1:0]        pc4_i,
    input  logic [DW-1:0]        ao_i,
    input  logic [DW-1:0]        rt_i,
    input  logic [AW-1:0]        fwd_addr_i,
    input  logic [NSRC*DW-1:0]   fwd_src_i,
    input  logic [SELW-1:0]      fwd_sel_i,
    input  logic                 cnt_clr_i,
    output logic                 valid_o,
    output logic [DW-1:0]        ir_o,
    output logic [DW-1:0]        pc4_o,
    output logic [DW-1:0]        ao_o,
    output logic [DW-1:0]        rt_o,
    output logic [AW-1:0]        fwd_addr_o,
    output logic [DW-1:0]        fwd_data_o,
    output logic                 fwd_valid_o,
    output logic [CNTW-1:0]      stall_cnt_o,
    output logic [CNTW-1:0]      bubble_cnt_o
);

    import cpu_pipe_pkg::*;

    localparam int unsigned BW = $clog2(NSRC * DW);

    logic          sel_ok;
    logic [BW-1:0] src_base;
    logic [DW-1:0] fwd_mux;
    logic          load;
    logic          stall_evt;
    logic          bubble_evt;

    // Out-of-range selects fall back to the ALU slice so the mux never reads past the bus
    assign sel_ok   = 32'(fwd_sel_i) < NSRC;
    assign src_base = sel_ok ? BW'(32'(fwd_sel_i) * DW) : BW'(FWD_SRC_ALU * DW);
    assign fwd_mux  = fwd_src_i[src_base +: DW];

    assign load       = !flush_i && !stall_i;
    assign stall_evt  = stall_i && !flush_i;
    assign bubble_evt = flush_i || (load && !valid_i);

    // Priority: flush > stall > load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_o    <= 1'b0;
            ir_o       <= '0;
            pc4_o      <= '0;
            ao_o       <= '0;
            rt_o       <= '0;
            fwd_addr_o <= '0;
            fwd_data_o <= '0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            ir_o       <= '0;
            pc4_o      <= '0;
            ao_o       <= '0;
            rt_o       <= '0;
            fwd_addr_o <= '0;
            fwd_data_o <= '0;
        end else if (load) begin
            valid_o    <= valid_i;
            ir_o       <= ir_i;
            pc4_o      <= pc4_i;
            ao_o       <= ao_i;
            rt_o       <= rt_i;
            fwd_addr_o <= valid_i ? fwd_addr_i : AW'(REG_ZERO);
            fwd_data_o <= fwd_mux;
        end
    end

    // Writes to register 0 are never forwarded
    assign fwd_valid_o = valid_o && (fwd_addr_o != AW'(REG_ZERO));

    pipe_sat_counter #(.CNTW(CNTW)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (cnt_clr_i),
        .inc   (stall_evt),
        .cnt   (stall_cnt_o)
    );

    pipe_sat_counter #(.CNTW(CNTW)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (cnt_clr_i),
        .inc   (bubble_evt),
        .cnt   (bubble_cnt_o)
    );

endmodule

// File: tb/tb_mem_stage_pipe_reg.sv
// Directed bench for mem_stage_pipe_reg: default instance plus a NSRC=3/CNTW=2 instance.
module tb_mem_stage_pipe_reg;

    logic        clk;
    logic        reset;
    logic        stall_i, flush_i, valid_i, cnt_clr_i;
    logic [31:0] ir_i, pc4_i, ao_i, rt_i;
    logic [4:0]  fwd_addr_i;
    logic [127:0] fwd_src_i;
    logic [1:0]  fwd_sel_i;
    logic [95:0] fwd_src_s;
    logic [1:0]  fwd_sel_s;

    logic        valid_o, fwd_valid_o;
    logic [31:0] ir_o, pc4_o, ao_o, rt_o, fwd_data_o;
    logic [4:0]  fwd_addr_o;
    logic [15:0] stall_cnt_o, bubble_cnt_o;

    logic        valid_s, fwd_valid_s;
    logic [31:0] ir_s, pc4_s, ao_s, rt_s, fwd_data_s;
    logic [4:0]  fwd_addr_s;
    logic [1:0]  stall_cnt_s, bubble_cnt_s;

    int checks = 0;
    int errors = 0;

    logic [197:0] got_bus, exp_bus;

    mem_stage_pipe_reg dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .ir_i(ir_i), .pc4_i(pc4_i), .ao_i(ao_i), .rt_i(rt_i), .fwd_addr_i(fwd_addr_i),
        .fwd_src_i(fwd_src_i), .fwd_sel_i(fwd_sel_i), .cnt_clr_i(cnt_clr_i),
        .valid_o(valid_o), .ir_o(ir_o), .pc4_o(pc4_o), .ao_o(ao_o), .rt_o(rt_o),
        .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o), .fwd_valid_o(fwd_valid_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    mem_stage_pipe_reg #(.NSRC(3), .CNTW(2)) dut_s (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .ir_i(ir_i), .pc4_i(pc4_i), .ao_i(ao_i), .rt_i(rt_i), .fwd_addr_i(fwd_addr_i),
        .fwd_src_i(fwd_src_s), .fwd_sel_i(fwd_sel_s), .cnt_clr_i(cnt_clr_i),
        .valid_o(valid_s), .ir_o(ir_s), .pc4_o(pc4_s), .ao_o(ao_s), .rt_o(rt_s),
        .fwd_addr_o(fwd_addr_s), .fwd_data_o(fwd_data_s), .fwd_valid_o(fwd_valid_s),
        .stall_cnt_o(stall_cnt_s), .bubble_cnt_o(bubble_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        stall_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b1; cnt_clr_i = 1'b0;
        ir_i = 32'hDEADBEEF; pc4_i = 32'h00400004; ao_i = 32'h12345678; rt_i = 32'h9ABCDEF0;
        fwd_addr_i = 5'd3; fwd_src_i = {4{32'hCAFEF00D}}; fwd_sel_i = 2'd1;
        fwd_src_s = {3{32'h0BADC0DE}}; fwd_sel_s = 2'd1;
        tick();
        stall_i = 1'b1;
        tick();
        checks++; if (fwd_valid_o !== 1'b1 || stall_cnt_o !== 16'd1) begin errors++;
            $display("FAIL pre_reset_load got fv=%b sc=%0d exp fv=1 sc=1", fwd_valid_o, stall_cnt_o); end
        reset = 1'b0;
        #1;
        got_bus = {ir_o, pc4_o, ao_o, rt_o, fwd_data_o, fwd_addr_o, valid_o};
        checks++; if (got_bus !== '0) begin errors++;
            $display("FAIL reset_regs got %h exp 0", got_bus); end
        checks++; if (fwd_valid_o !== 1'b0 || stall_cnt_o !== 16'd0 || bubble_cnt_o !== 16'd0) begin errors++;
            $display("FAIL reset_cnt got fv=%b sc=%0d bc=%0d exp 0 0 0", fwd_valid_o, stall_cnt_o, bubble_cnt_o); end
        checks++; if ({valid_s, fwd_data_s, stall_cnt_s, bubble_cnt_s} !== '0) begin errors++;
            $display("FAIL reset_small got v=%b d=%h sc=%0d bc=%0d exp 0", valid_s, fwd_data_s, stall_cnt_s, bubble_cnt_s); end
        #2;
        reset = 1'b1;
        stall_i = 1'b0;
    endtask

    task automatic test_load();
        clear_counters();
        valid_i = 1'b1; ir_i = 32'h8C220004; pc4_i = 32'h00400010; ao_i = 32'h00001000;
        rt_i = 32'h00000055; fwd_addr_i = 5'd2;
        fwd_src_i = {32'h0000BBBB, 32'h0000AAAA, 32'h00003008, 32'h00001000}; fwd_sel_i = 2'd0;
        tick();
        checks++; if (ao_o !== 32'h00001000 || ir_o !== 32'h8C220004) begin errors++;
            $display("FAIL load_payload got ao=%h ir=%h exp 00001000 8c220004", ao_o, ir_o); end
        checks++; if (pc4_o !== 32'h00400010 || rt_o !== 32'h00000055 || valid_o !== 1'b1 || fwd_addr_o !== 5'd2) begin errors++;
            $display("FAIL load_rest got pc4=%h rt=%h v=%b a=%0d", pc4_o, rt_o, valid_o, fwd_addr_o); end
        checks++; if (fwd_data_o !== 32'h00001000 || fwd_valid_o !== 1'b1) begin errors++;
            $display("FAIL load_sel0 got d=%h fv=%b exp 00001000 1", fwd_data_o, fwd_valid_o); end
        fwd_sel_i = 2'd1;
        tick();
        checks++; if (fwd_data_o !== 32'h00003008) begin errors++;
            $display("FAIL load_sel1 got %h exp 00003008", fwd_data_o); end
        fwd_sel_i = 2'd3;
        tick();
        checks++; if (fwd_data_o !== 32'h0000BBBB) begin errors++;
            $display("FAIL load_sel3 got %h exp 0000bbbb", fwd_data_o); end
        checks++; if (bubble_cnt_o !== 16'd0 || stall_cnt_o !== 16'd0) begin errors++;
            $display("FAIL load_cnt got sc=%0d bc=%0d exp 0 0", stall_cnt_o, bubble_cnt_o); end
    endtask

    task automatic test_reg_zero_oor();
        clear_counters();
        valid_i = 1'b1; fwd_addr_i = 5'd0;
        fwd_src_s = {32'h33333333, 32'h22222222, 32'h11111111}; fwd_sel_s = 2'd3;
        tick();
        checks++; if (fwd_valid_o !== 1'b0 || valid_o !== 1'b1) begin errors++;
            $display("FAIL reg_zero got fv=%b v=%b exp 0 1", fwd_valid_o, valid_o); end
        checks++; if (fwd_data_s !== 32'h11111111) begin errors++;
            $display("FAIL sel_oor got %h exp 11111111", fwd_data_s); end
        valid_i = 1'b0; fwd_addr_i = 5'd5; fwd_sel_s = 2'd2;
        tick();
        checks++; if (fwd_addr_o !== 5'd0 || valid_o !== 1'b0 || fwd_valid_o !== 1'b0) begin errors++;
            $display("FAIL invalid_load got a=%0d v=%b fv=%b exp 0 0 0", fwd_addr_o, valid_o, fwd_valid_o); end
        checks++; if (bubble_cnt_o !== 16'd1) begin errors++;
            $display("FAIL invalid_bubble got %0d exp 1", bubble_cnt_o); end
        checks++; if (fwd_data_s !== 32'h33333333) begin errors++;
            $display("FAIL sel2_small got %h exp 33333333", fwd_data_s); end
    endtask

    task automatic test_stall();
        clear_counters();
        valid_i = 1'b1; ir_i = 32'h00A00001; pc4_i = 32'h00000104; ao_i = 32'h000000A0;
        rt_i = 32'h000000A1; fwd_addr_i = 5'd7; fwd_src_i = {96'h0, 32'h000000A0}; fwd_sel_i = 2'd0;
        tick();
        exp_bus = {32'h00A00001, 32'h00000104, 32'h000000A0, 32'h000000A1, 32'h000000A0, 5'd7, 1'b1};
        stall_i = 1'b1;
        ir_i = 32'h00B00002; pc4_i = 32'h00000108; ao_i = 32'h000000B0;
        rt_i = 32'h000000B1; fwd_addr_i = 5'd9; fwd_src_i = {96'h0, 32'h000000B0};
        for (int i = 0; i < 3; i++) begin
            tick();
            got_bus = {ir_o, pc4_o, ao_o, rt_o, fwd_data_o, fwd_addr_o, valid_o};
            checks++; if (got_bus !== exp_bus) begin errors++;
                $display("FAIL stall_hold%0d got %h exp %h", i, got_bus, exp_bus); end
        end
        checks++; if (stall_cnt_o !== 16'd3 || stall_cnt_s !== 2'd3) begin errors++;
            $display("FAIL stall_cnt got %0d/%0d exp 3/3", stall_cnt_o, stall_cnt_s); end
        stall_i = 1'b0;
        tick();
        exp_bus = {32'h00B00002, 32'h00000108, 32'h000000B0, 32'h000000B1, 32'h000000B0, 5'd9, 1'b1};
        got_bus = {ir_o, pc4_o, ao_o, rt_o, fwd_data_o, fwd_addr_o, valid_o};
        checks++; if (got_bus !== exp_bus || stall_cnt_o !== 16'd3) begin errors++;
            $display("FAIL stall_release got %h sc=%0d exp %h sc=3", got_bus, stall_cnt_o, exp_bus); end
    endtask

    task automatic test_flush_vs_stall();
        clear_counters();
        valid_i = 1'b1; ir_i = 32'h00C00003; ao_i = 32'h000000C0; fwd_addr_i = 5'd4;
        fwd_src_i = {96'h0, 32'h000000C0}; fwd_sel_i = 2'd0;
        tick();
        stall_i = 1'b1; flush_i = 1'b1;
        tick();
        got_bus = {ir_o, pc4_o, ao_o, rt_o, fwd_data_o, fwd_addr_o, valid_o};
        checks++; if (got_bus !== '0 || fwd_valid_o !== 1'b0) begin errors++;
            $display("FAIL flush_regs got %h fv=%b exp 0", got_bus, fwd_valid_o); end
        checks++; if (bubble_cnt_o !== 16'd1 || stall_cnt_o !== 16'd0) begin errors++;
            $display("FAIL flush_cnt got bc=%0d sc=%0d exp 1 0", bubble_cnt_o, stall_cnt_o); end
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_saturation();
        clear_counters();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (stall_cnt_s !== 2'd3 || stall_cnt_o !== 16'd5) begin errors++;
            $display("FAIL sat_cnt got %0d/%0d exp 3/5", stall_cnt_s, stall_cnt_o); end
        cnt_clr_i = 1'b1;
        tick();
        checks++; if (stall_cnt_s !== 2'd0 || stall_cnt_o !== 16'd0) begin errors++;
            $display("FAIL clr_cnt got %0d/%0d exp 0/0", stall_cnt_s, stall_cnt_o); end
        cnt_clr_i = 1'b0;
        tick();
        checks++; if (stall_cnt_s !== 2'd1 || stall_cnt_o !== 16'd1) begin errors++;
            $display("FAIL post_clr_cnt got %0d/%0d exp 1/1", stall_cnt_s, stall_cnt_o); end
        stall_i = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; cnt_clr_i = 1'b0;
        ir_i = '0; pc4_i = '0; ao_i = '0; rt_i = '0; fwd_addr_i = '0;
        fwd_src_i = '0; fwd_sel_i = '0; fwd_src_s = '0; fwd_sel_s = '0;
        #12;
        reset = 1'b1;
        test_reset();
        test_load();
        test_reg_zero_oor();
        test_stall();
        test_flush_vs_stall();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
